cnt_random_seq_param: RTL and testbench

Parametrised successor to the team's fixed 3-bit scrambled-sequence counter. It produces either a plain binary count or a full-period pseudo-random sequence over WIDTH bits. The pseudo-random mode uses a de Bruijn-extended Fibonacci LFSR, which also visits the all-zero state. The block adds step enable, synchronous load of value and mode, and a period-complete pulse, and drives LED or pattern outputs directly.

---
 rtl/cnt_random_seq_param.sv | 58 +++++
 tb/tb_cnt_random_seq_param.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_random_seq_param.sv
// Parametrised step counter: binary up-count or full-period scrambled sequence
// (de Bruijn-extended Fibonacci LFSR), with step enable, load and period wrap pulse.
module cnt_random_seq_param #(
  parameter int              WIDTH    = 3,
  parameter logic [WIDTH-1:0] TAPS    = 3'b110,
  parameter logic [WIDTH-1:0] SEED    = '0,
  parameter bit              MODE_RST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             mode_q
);

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] POS_LAST = '1;

  logic [WIDTH-1:0] pos;
  logic [WIDTH-1:0] q_next;
  logic             fb;

  // The zero-detect term splices the all-zero state into the LFSR cycle,
  // so the scrambled sequence covers all 2^WIDTH values.
  always_comb begin
    fb = (^(q & TAPS)) ^ (q[WIDTH-2:0] == '0);
    if (mode_q) begin
      q_next = {q[WIDTH-2:0], fb};
    end else begin
      q_next = q + ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q      <= SEED;
      mode_q <= MODE_RST;
      pos    <= '0;
      wrap   <= 1'b0;
    end else if (load) begin
      q      <= load_val;
      mode_q <= mode;
      pos    <= '0;
      wrap   <= 1'b0;
    end else if (en) begin
      q      <= q_next;
      pos    <= pos + ONE;
      wrap   <= (pos == POS_LAST);
    end else begin
      wrap   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cnt_random_seq_param.sv
// Bench for cnt_random_seq_param: vector table, reference-model sequences and a
// WIDTH=8 full-period sweep, all checked through an expected-value queue.
module tb_cnt_random_seq_param;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en, load, mode;
  logic [2:0] load_val;
  logic [2:0] q;
  logic       wrap, mode_q;

  logic       en8, load8, mode8;
  logic [7:0] load_val8, q8;
  logic       wrap8, mode_q8;

  int checks = 0;
  int errors = 0;
  int wrap_cnt = 0;

  logic [2:0] m_q;
  logic       m_mode;
  int         m_pos;

  typedef struct {
    logic [2:0] q;
    logic       wrap;
    logic       mq;
    string      name;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic       ld;
    logic       en;
    logic [2:0] val;
    logic       md;
    logic [2:0] q;
    logic       wrap;
    logic       mq;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  cnt_random_seq_param dut3 (
    .clk(clk), .reset_n(reset_n), .en(en), .load(load), .load_val(load_val),
    .mode(mode), .q(q), .wrap(wrap), .mode_q(mode_q)
  );

  cnt_random_seq_param #(.WIDTH(8), .TAPS(8'hB8)) dut8 (
    .clk(clk), .reset_n(reset_n), .en(en8), .load(load8), .load_val(load_val8),
    .mode(mode8), .q(q8), .wrap(wrap8), .mode_q(mode_q8)
  );

  // Reference step built bit by bit from the sequence definition.
  function automatic logic [15:0] ref_next(input logic [15:0] s, input int w,
                                           input logic [15:0] taps, input logic md);
    logic        fb;
    logic        zero;
    logic [15:0] mask;
    logic [15:0] r;
    mask = 16'hFFFF >> (16 - w);
    if (!md) begin
      r = (s + 16'd1) & mask;
    end else begin
      fb   = 1'b0;
      zero = 1'b1;
      for (int i = 0; i < w; i++) begin
        if (taps[i] && s[i]) fb = ~fb;
        if (i < w - 1 && s[i]) zero = 1'b0;
      end
      r = ((s << 1) | {15'd0, fb ^ zero}) & mask;
    end
    return r;
  endfunction

  function automatic void add_vec(input logic ld, input logic e_i, input logic [2:0] val,
                                  input logic md, input logic [2:0] eq, input logic ew,
                                  input logic em);
    vec_t v;
    v.ld = ld; v.en = e_i; v.val = val; v.md = md;
    v.q = eq; v.wrap = ew; v.mq = em;
    vecs.push_back(v);
  endfunction

  task automatic push_exp(input logic [2:0] eq, input logic ew, input logic em, input string nm);
    exp_t x;
    x.q = eq; x.wrap = ew; x.mq = em; x.name = nm;
    sb.push_back(x);
  endtask

  task automatic check_output();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty: DUT output sampled with no expected entry");
    end else begin
      e = sb.pop_front();
      if (q !== e.q || wrap !== e.wrap || mode_q !== e.mq) begin
        errors++;
        $display("[TB] FAIL %s: got q=%b wrap=%b mode_q=%b, expected q=%b wrap=%b mode_q=%b",
                 e.name, q, wrap, mode_q, e.q, e.wrap, e.mq);
      end
    end
  endtask

  task automatic apply_stimulus(input logic ld, input logic e_i, input logic [2:0] val,
                                input logic md, input logic [2:0] eq, input logic ew,
                                input logic em, input string nm);
    load = ld; en = e_i; load_val = val; mode = md;
    push_exp(eq, ew, em, nm);
    @(posedge clk);
    #1;
    check_output();
    if (wrap === 1'b1) wrap_cnt++;
  endtask

  task automatic model_step(input logic ld, input logic e_i, input logic [2:0] val,
                            input logic md, input string nm);
    logic        w;
    logic [15:0] t;
    w = 1'b0;
    if (ld) begin
      m_q = val; m_mode = md; m_pos = 0;
    end else if (e_i) begin
      t = ref_next({13'd0, m_q}, 3, 16'h0006, m_mode);
      m_q = t[2:0];
      w = (m_pos == 7);
      m_pos = (m_pos + 1) % 8;
    end
    apply_stimulus(ld, e_i, val, md, m_q, w, m_mode, nm);
  endtask

  // Called just after a rising edge; asserts reset mid-cycle and checks it took effect.
  task automatic do_reset(input string nm);
    load = 1'b0; en = 1'b0; en8 = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    m_q = 3'b000; m_mode = 1'b1; m_pos = 0;
    push_exp(3'b000, 1'b0, 1'b1, nm);
    check_output();
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_cond(input bit ok, input string nm, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0]  scr [8];
    logic [2:0]  bin [8];
    int          wc0;
    int          bad8, dup8, miss8, xcnt8, wc8;
    logic [15:0] m8;
    bit          seen [256];

    scr = '{3'b001, 3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000};
    bin = '{3'b111, 3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110};

    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 8; k++)
        add_vec(1'b0, 1'b1, 3'b000, 1'b1, scr[k], k == 7, 1'b1);
    add_vec(1'b1, 1'b0, 3'b110, 1'b0, 3'b110, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++)
      add_vec(1'b0, 1'b1, 3'b000, 1'b0, bin[k], k == 7, 1'b0);
    add_vec(1'b0, 1'b0, 3'b000, 1'b0, 3'b110, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 3'b000, 1'b1, 3'b111, 1'b0, 1'b0);
    add_vec(1'b1, 1'b0, 3'b111, 1'b1, 3'b111, 1'b0, 1'b1);
    add_vec(1'b0, 1'b1, 3'b000, 1'b0, 3'b110, 1'b0, 1'b1);

    reset_n = 1'b1; en = 1'b0; load = 1'b0; load_val = 3'b000; mode = 1'b0;
    en8 = 1'b0; load8 = 1'b0; load_val8 = 8'h00; mode8 = 1'b0;

    @(posedge clk);
    #1;
    do_reset("rst_init");
    model_step(1'b1, 1'b0, 3'b101, 1'b0, "pre_load");
    do_reset("rst_async");

    for (int i = 0; i < vecs.size(); i++)
      apply_stimulus(vecs[i].ld, vecs[i].en, vecs[i].val, vecs[i].md,
                     vecs[i].q, vecs[i].wrap, vecs[i].mq, $sformatf("vec%0d", i));

    // Load together with en on the step that would have wrapped.
    do_reset("rst_prio");
    for (int i = 0; i < 7; i++) model_step(1'b0, 1'b1, 3'b000, 1'b0, "prio_pre");
    model_step(1'b1, 1'b1, 3'b011, 1'b1, "prio_load");
    wc0 = wrap_cnt;
    for (int i = 0; i < 8; i++) model_step(1'b0, 1'b1, 3'b000, 1'b0, "prio_post");
    check_cond(wrap_cnt - wc0 == 1 && q === 3'b011, "prio_wrap_count", wrap_cnt - wc0, 1);

    do_reset("rst_gap");
    wc0 = wrap_cnt;
    for (int i = 0; i < 16; i++) model_step(1'b0, (i % 2) == 0, 3'b000, 1'b1, "gap");
    check_cond(wrap_cnt - wc0 == 1, "gap_wrap_count", wrap_cnt - wc0, 1);

    // A reset mid-period must discard the step count.
    do_reset("rst_pre_mid");
    for (int i = 0; i < 5; i++) model_step(1'b0, 1'b1, 3'b000, 1'b0, "mid_pre");
    do_reset("rst_midrun");
    wc0 = wrap_cnt;
    for (int i = 0; i < 8; i++) model_step(1'b0, 1'b1, 3'b000, 1'b0, "mid_post");
    check_cond(wrap_cnt - wc0 == 1, "mid_wrap_count", wrap_cnt - wc0, 1);

    do_reset("rst_w8");
    check_cond(q8 === 8'h00 && wrap8 === 1'b0 && mode_q8 === 1'b1, "w8_reset", int'(q8), 0);
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    bad8 = 0; dup8 = 0; xcnt8 = 0; wc8 = 0; m8 = 16'h0000;
    en8 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk);
      #1;
      m8 = ref_next(m8, 8, 16'h00B8, 1'b1);
      if (q8 !== m8[7:0]) bad8++;
      if ($isunknown(q8)) begin
        xcnt8++;
      end else begin
        if (seen[q8]) dup8++;
        seen[q8] = 1'b1;
      end
      if (wrap8 === 1'b1) begin
        wc8++;
        if (i != 255) bad8++;
      end
    end
    miss8 = 0;
    for (int i = 0; i < 256; i++) if (!seen[i]) miss8++;
    check_cond(bad8 == 0, "w8_sequence", bad8, 0);
    check_cond(dup8 == 0 && miss8 == 0 && xcnt8 == 0, "w8_coverage", dup8 + miss8 + xcnt8, 0);
    check_cond(wc8 == 1, "w8_wrap_count", wc8, 1);
    check_cond(wrap8 === 1'b1 && q8 === 8'h00, "w8_wrap_at_start", int'(q8), 0);
    en8 = 1'b0;
    @(posedge clk);
    #1;
    check_cond(wrap8 === 1'b0 && q8 === 8'h00, "w8_hold", int'(wrap8), 0);

    check_cond(sb.size() == 0, "scoreboard_drain", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
